// File: rtl/keypad_scanner.sv
// keypad_scanner: 5x4 matrix keypad scanner with frame-level debounce; optional auto-repeat via KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] row,
  input  logic [3:0] col,
  output logic [4:0] keyCode,
  output logic       keyReady,
  output logic       keyHeld
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_FRAMES);
  localparam logic [4:0] NO_KEY = 5'h1F;

  if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 2 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [3:0] colMeta, colSync;
  logic [DW-1:0] divCnt;
  logic [2:0] rowIdx;
  logic accAny, accMulti;
  logic [4:0] accCode;
  logic slotEnd, frameEnd;
  logic [2:0] zeros;
  logic [1:0] slotCol;
  logic [4:0] slotCode, fCode;
  logic slotOne, fAny, fMulti, frameNone, heldMatch, repPulse;

  state_t state, stateNx;
  logic [CW-1:0] cnt, cntNx;
  logic [4:0] cand, candNx, codeNx;
  logic readyNx, heldNx;

  assign row       = ~(5'd1 << rowIdx);
  assign slotEnd   = divCnt == DIV_LAST;
  assign frameEnd  = slotEnd && rowIdx == 3'd4;
  assign zeros     = {2'b0, ~colSync[0]} + {2'b0, ~colSync[1]} + {2'b0, ~colSync[2]} + {2'b0, ~colSync[3]};
  assign slotCol   = !colSync[0] ? 2'd0 : !colSync[1] ? 2'd1 : !colSync[2] ? 2'd2 : 2'd3;
  assign slotCode  = {rowIdx, slotCol};
  assign slotOne   = zeros == 3'd1;
  // The frame result folds in the final slot's sample combinationally so it is ready on the sampling edge.
  assign fMulti    = accMulti || zeros > 3'd1 || (slotOne && accAny);
  assign fAny      = accAny || zeros != 3'd0;
  assign fCode     = slotOne ? slotCode : accCode;
  assign frameNone = !fAny || fMulti;
  assign heldMatch = !frameNone && fCode == keyCode;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      colMeta  <= 4'hF;
      colSync  <= 4'hF;
      divCnt   <= '0;
      rowIdx   <= 3'd0;
      accAny   <= 1'b0;
      accMulti <= 1'b0;
      accCode  <= NO_KEY;
    end else begin
      colMeta <= col;
      colSync <= colMeta;
      divCnt  <= slotEnd ? '0 : divCnt + 1'b1;
      if (slotEnd) begin
        rowIdx   <= frameEnd ? 3'd0 : rowIdx + 3'd1;
        accAny   <= !frameEnd && fAny;
        accMulti <= !frameEnd && fMulti;
        accCode  <= frameEnd ? NO_KEY : fCode;
      end
    end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] repCnt;
  logic repHit;
  assign repHit   = frameEnd && state == HELD && heldMatch;
  assign repPulse = repHit && repCnt == REP_LAST;
  // Held at zero outside HELD, so every entry into HELD starts a fresh repeat period.
  always_ff @(posedge clk or posedge rst)
    if (rst) repCnt <= '0;
    else if (state != HELD) repCnt <= '0;
    else if (repHit) repCnt <= repPulse ? '0 : repCnt + 1'b1;
`else
  assign repPulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= NO_KEY;
      keyCode  <= NO_KEY;
      keyReady <= 1'b0;
      keyHeld  <= 1'b0;
    end else begin
      state    <= stateNx;
      cnt      <= cntNx;
      cand     <= candNx;
      keyCode  <= codeNx;
      keyReady <= readyNx;
      keyHeld  <= heldNx;
    end

  always_comb begin
    stateNx = state;
    cntNx   = cnt;
    candNx  = cand;
    codeNx  = keyCode;
    readyNx = 1'b0;
    heldNx  = keyHeld;
    if (frameEnd)
      case (state)
        IDLE:
          if (!frameNone) begin
            stateNx = PRESS_DB;
            candNx  = fCode;
            cntNx   = CW'(1);
          end
        PRESS_DB:
          if (frameNone) begin
            stateNx = IDLE;
            cntNx   = '0;
            candNx  = NO_KEY;
          end else if (fCode == cand) begin
            cntNx = cnt + 1'b1;
            if (cntNx == DB) begin
              stateNx = HELD;
              codeNx  = cand;
              heldNx  = 1'b1;
              readyNx = 1'b1;
            end
          end else begin
            candNx = fCode;
            cntNx  = CW'(1);
          end
        HELD:
          if (!heldMatch) begin
            stateNx = RELEASE_DB;
            cntNx   = CW'(1);
          end else readyNx = repPulse;
        default:
          if (heldMatch) stateNx = HELD;
          else begin
            cntNx = cnt + 1'b1;
            if (cntNx == DB) begin
              stateNx = IDLE;
              cntNx   = '0;
              candNx  = NO_KEY;
              codeNx  = NO_KEY;
              heldNx  = 1'b0;
            end
          end
      endcase
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a behavioural key-matrix model.
module tb_keypad_scanner;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] row, keyCode;
  logic [3:0] col;
  logic keyReady, keyHeld;
  logic [19:0] pressed = '0;
  logic [4:0] expQ[$];
  logic [4:0] expCode;
  logic prevReady = 1'b0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(5)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .keyCode(keyCode), .keyReady(keyReady), .keyHeld(keyHeld)
  );

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 5; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (keyReady) begin
      checks++;
      if (rst) begin
        errors++;
        $display("FAIL ready_in_reset keyReady=1 expected 0");
      end else if (prevReady) begin
        errors++;
        $display("FAIL ready_width keyReady high two cycles, expected one");
      end else if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse keyCode=%h expected no pulse", keyCode);
      end else begin
        expCode = expQ.pop_front();
        if (keyCode !== expCode) begin
          errors++;
          $display("FAIL pulse_code keyCode=%h expected %h", keyCode, expCode);
        end
      end
    end
    prevReady = keyReady;
  end

  task automatic run(input logic [19:0] m, input int cycles);
    pressed = m;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    pressed = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({row, keyCode, keyReady, keyHeld} !== {5'b11110, 5'h1F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state row=%b code=%h rdy=%b held=%b expected 11110 1f 0 0", row, keyCode, keyReady, keyHeld);
    end
    expQ.push_back(5'h09);
    run(20'h1 << 9, 60);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({row, keyCode, keyReady, keyHeld} !== {5'b11110, 5'h1F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midscan_reset row=%b code=%h rdy=%b held=%b expected 11110 1f 0 0", row, keyCode, keyReady, keyHeld);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (row !== 5'b11110) begin
      errors++;
      $display("FAIL restart_row0 row=%b expected 11110", row);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row !== 5'b11101) begin
      errors++;
      $display("FAIL restart_row1 row=%b expected 11101", row);
    end
    run(20'h1 << 9, 36);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL reset_rebounce code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    expQ.push_back(5'h09);
    run(20'h1 << 9, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h09, 1'b1} || expQ.size() != 0) begin
      errors++;
      $display("FAIL reset_reaccept code=%h held=%b pending=%0d expected 09 1 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_single();
    do_reset();
    run(20'h1 << 9, 40);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL single_early code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    expQ.push_back(5'h09);
    run(20'h1 << 9, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h09, 1'b1}) begin
      errors++;
      $display("FAIL single_accept code=%h held=%b expected 09 1", keyCode, keyHeld);
    end
    run(20'h1 << 9, 80);
    checks++;
    if ({keyCode, keyHeld} !== {5'h09, 1'b1} || expQ.size() != 0) begin
      errors++;
      $display("FAIL single_hold code=%h held=%b pending=%0d expected 09 1 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_bounce();
    do_reset();
    run(20'h1 << 14, 40);
    run('0, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL bounce_gap code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    expQ.push_back(5'h0E);
    run(20'h1 << 14, 60);
    checks++;
    if ({keyCode, keyHeld} !== {5'h0E, 1'b1} || expQ.size() != 0) begin
      errors++;
      $display("FAIL bounce_accept code=%h held=%b pending=%0d expected 0e 1 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_multi();
    do_reset();
    run((20'h1 << 12) | (20'h1 << 14), 200);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL multi_same_row code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    run((20'h1 << 1) | (20'h1 << 18), 80);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL multi_cross_row code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
  endtask

  task automatic test_release();
    do_reset();
    expQ.push_back(5'h11);
    run(20'h1 << 17, 60);
    run('0, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h11, 1'b1}) begin
      errors++;
      $display("FAIL release_glitch code=%h held=%b expected 11 1", keyCode, keyHeld);
    end
    run(20'h1 << 17, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h11, 1'b1}) begin
      errors++;
      $display("FAIL release_repress code=%h held=%b expected 11 1", keyCode, keyHeld);
    end
    run('0, 60);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0} || expQ.size() != 0) begin
      errors++;
      $display("FAIL release_done code=%h held=%b pending=%0d expected 1f 0 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_other_while_held();
    do_reset();
    expQ.push_back(5'h00);
    run(20'h1, 60);
    run(20'h1 << 19, 40);
    checks++;
    if ({keyCode, keyHeld} !== {5'h00, 1'b1}) begin
      errors++;
      $display("FAIL other_keeps_code code=%h held=%b expected 00 1", keyCode, keyHeld);
    end
    run(20'h1 << 19, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL other_released code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    run(20'h1 << 19, 40);
    checks++;
    if ({keyCode, keyHeld} !== {5'h1F, 1'b0}) begin
      errors++;
      $display("FAIL other_debouncing code=%h held=%b expected 1f 0", keyCode, keyHeld);
    end
    expQ.push_back(5'h13);
    run(20'h1 << 19, 20);
    checks++;
    if ({keyCode, keyHeld} !== {5'h13, 1'b1} || expQ.size() != 0) begin
      errors++;
      $display("FAIL other_accept code=%h held=%b pending=%0d expected 13 1 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_repeat();
    do_reset();
    expQ.push_back(5'h0C);
`ifdef KEYPAD_REPEAT_EN
    repeat (3) expQ.push_back(5'h0C);
`endif
    run(20'h1 << 12, 360);
    checks++;
    if ({keyCode, keyHeld} !== {5'h0C, 1'b1} || expQ.size() != 0) begin
      errors++;
      $display("FAIL repeat_count code=%h held=%b pending=%0d expected 0c 1 0", keyCode, keyHeld, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_release();
    test_other_while_held();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, the number of clock cycles each row stays driven; legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, the number of consecutive agreeing frames required to accept a press or release; legal values are 2 or more.
REQ-003 SHALL have parameter REPEAT_FRAMES, default 20, the auto-repeat period in frames; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; everything is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port row, output, 5 bits: active-low row drive, exactly one bit low at all times.
REQ-007 SHALL have port col, input, 4 bits: active-low column sense, asynchronous, externally pulled up.
REQ-008 SHALL have port keyCode, output, 5 bits: code of the accepted key, row*4+col (0x00-0x13); 5'h1F when no key is accepted.
REQ-009 SHALL have port keyReady, output, 1 bit: one-cycle pulse when a new key is accepted (and on each repeat).
REQ-010 SHALL have port keyHeld, output, 1 bit: high while a key is accepted (states HELD and RELEASE_DB).

Function
REQ-011 SHALL pass col through a 2-flop synchronizer before any use.
REQ-012 SHALL divide time into row slots of SCAN_DIV cycles, drive row r low during slot r, and step r 0->1->2->3->4->0.
REQ-013 SHALL sample the synchronized col on the last cycle of each slot; a low bit c in slot r marks key r*4+c.
REQ-014 SHALL treat slots 0-4 as one frame; at the end of each frame the result is NONE, a single key code K, or MULTI (two or more keys).
REQ-015 SHALL treat MULTI exactly like NONE.
REQ-016 SHALL run a state machine with states IDLE, PRESS_DB, HELD and RELEASE_DB, evaluated only at frame end; frame counter cnt.
REQ-017 SHALL, in IDLE, move on result K to PRESS_DB with cand=K and cnt=1; on NONE it stays in IDLE.
REQ-018 SHALL, in PRESS_DB:
- on K==cand, increment cnt, and when cnt reaches DEBOUNCE_FRAMES go to HELD;
- on K!=cand, set cand=K and cnt=1;
- on NONE, return to IDLE.
REQ-019 SHALL, on the PRESS_DB->HELD transition, load keyCode=cand, set keyHeld=1 and pulse keyReady, all in the cycle after the frame-end sample.
REQ-020 SHALL, in HELD, go to RELEASE_DB with cnt=1 on any result other than keyCode.
REQ-021 SHALL, in RELEASE_DB:
- on result==keyCode, return to HELD with no keyReady pulse;
- otherwise increment cnt, and at DEBOUNCE_FRAMES go to IDLE with keyCode=5'h1F and keyHeld=0.
REQ-022 SHALL pulse keyReady for exactly one cycle per acceptance and never while rst is high.
REQ-023 SHALL keep keyCode stable between acceptance and release; a different key pressed while one is held is accepted only after release and a new debounce from IDLE.

Reset
REQ-024 SHALL, while rst is high, asynchronously force:
- row=5'b11110 and slot cycle counter=0;
- synchronizer flops=4'hF;
- state=IDLE, cnt=0, cand=5'h1F;
- keyCode=5'h1F, keyReady=0, keyHeld=0.
REQ-025 SHALL, when rst asserts mid-frame or mid-debounce, discard the partial frame, so that scanning restarts at row 0 on the first clock after rst falls.

Configuration
REQ-026 SHALL, with KEYPAD_REPEAT_EN defined, count frames in HELD whose result equals keyCode and pulse keyReady (keyCode unchanged) every REPEAT_FRAMES-th such frame; this counter clears on every entry to HELD.
REQ-027 SHALL, without KEYPAD_REPEAT_EN, contain no repeat logic and pulse keyReady only on acceptance.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_FRAMES=5; frame = 20 cycles)
REQ-028 SHALL cover: rst pulsed mid-scan -> row=5'b11110, keyCode=5'h1F, keyReady=0, keyHeld=0 immediately; row 0 on first clock after release.
REQ-029 SHALL cover: col[1] low whenever row[2] low, held steadily -> after frame 3, one keyReady pulse with keyCode=5'h09, keyHeld=1; no further pulses (repeat disabled).
REQ-030 SHALL cover: key r3c2 for 2 frames, released 1 frame, then pressed 3 frames -> exactly one pulse, keyCode=5'h0E.
REQ-031 SHALL cover: r3c0 and r3c2 pressed together for 10 frames -> no pulse, keyCode stays 5'h1F.
REQ-032 SHALL cover release:
- 5'h11 held, then released for 1 frame and re-pressed -> keyCode stays 5'h11, no pulse;
- then released for 3 frames -> keyCode=5'h1F, keyHeld=0.
REQ-033 SHALL cover: with KEYPAD_REPEAT_EN, r3c0 held for 18 frames -> 4 pulses, all with keyCode=5'h0C; without the macro -> 1 pulse.
